// File: rtl/scan_sel_gen_pkg.sv
// Shared types and helpers for the scan select generator: FSM states, select width
// and the one-step code stepping/rollover rules used by the top.
package scan_sel_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;
  localparam sel_t SEL_MAX = 2'd3;

  function automatic sel_t step_sel(input sel_t sel, input logic down);
    return down ? sel - sel_t'(1) : sel + sel_t'(1);
  endfunction

  // A rollover is 3->0 counting up, or 0->3 counting down.
  function automatic logic is_rollover(input sel_t sel, input logic down);
    return down ? (sel == '0) : (sel == SEL_MAX);
  endfunction

endpackage

// File: rtl/scan_sel_gen_dwell_cnt.sv
// Dwell counter: counts enabled cycles 0..DWELL-1 and flags the last one on tc.
// clr restarts the dwell; counting stops (holds) whenever en is low.
module scan_sel_gen_dwell_cnt #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [DWELL_W-1:0] cnt;

  assign tc = (cnt == DWELL_W'(DWELL - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Select generator driving a 2-to-4 decoder's A/B inputs through 0,1,2,3 with a
// programmable dwell. Optional macro SCAN_DIR_EN adds a dir input (1 = count down).
module scan_sel_gen
  import scan_sel_gen_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] load_sel,
`ifdef SCAN_DIR_EN
  input  logic       dir,
`endif
  output logic       a,
  output logic       b,
  output logic       valid,
  output logic       wrap
);

  state_t state;
  sel_t   sel;
  logic   tc;
  logic   cnt_en;
  logic   down;

`ifdef SCAN_DIR_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // Only a running, enabled cycle consumes dwell; a load restarts it instead.
  assign cnt_en = (state == ST_RUN) && en && !load;

  scan_sel_gen_dwell_cnt #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (load),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= en ? ST_RUN : ST_IDLE;
      wrap  <= 1'b0;
      if (load) begin
        sel <= load_sel;
      end else if (cnt_en && tc) begin
        sel  <= step_sel(sel, down);
        wrap <= is_rollover(sel, down);
      end
    end
  end

  // a and b come from one register so the decoder never sees a split transition.
  assign {b, a} = sel;
  assign valid  = (state == ST_RUN);

endmodule

// File: tb/tb_scan_sel_gen.sv
// Randomized bench for scan_sel_gen (DWELL=4 and DWELL=1 instances) against a
// cycle-level behavioural model, plus literal expectations for the opening run.
`timescale 1ns / 1ps
module tb_scan_sel_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [1:0] load_sel;
  logic       dir;

  logic a4, b4, valid4, wrap4;
  logic a1, b1, valid1, wrap1;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  scan_sel_gen #(.DWELL(4), .DWELL_W(8)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_sel (load_sel),
`ifdef SCAN_DIR_EN
    .dir      (dir),
`endif
    .a        (a4),
    .b        (b4),
    .valid    (valid4),
    .wrap     (wrap4)
  );

  scan_sel_gen #(.DWELL(1), .DWELL_W(8)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_sel (load_sel),
`ifdef SCAN_DIR_EN
    .dir      (dir),
`endif
    .a        (a1),
    .b        (b1),
    .valid    (valid1),
    .wrap     (wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dwell_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Behavioural model: code 0..3, count of RUN cycles already spent on it.
  int m_code [2];
  int m_held [2];
  bit m_valid[2];
  bit m_wrap [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_code[k]  = 0;
        m_held[k]  = 0;
        m_valid[k] = 0;
        m_wrap[k]  = 0;
      end else begin
        m_wrap[k] = 0;
        if (load) begin
          m_code[k] = int'(load_sel);
          m_held[k] = 0;
        end else if (m_valid[k] && en) begin
          m_held[k] = m_held[k] + 1;
          if (m_held[k] == dwell_of(k)) begin
            m_held[k] = 0;
            if (dir) begin
              m_wrap[k] = (m_code[k] == 0);
              m_code[k] = (m_code[k] + 3) % 4;
            end else begin
              m_wrap[k] = (m_code[k] == 3);
              m_code[k] = (m_code[k] + 1) % 4;
            end
          end
        end
        m_valid[k] = en;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("dw4.sel",   int'({b4, a4}), m_code[0]);
      check("dw4.valid", int'(valid4),   int'(m_valid[0]));
      check("dw4.wrap",  int'(wrap4),    int'(m_wrap[0]));
      check("dw1.sel",   int'({b1, a1}), m_code[1]);
      check("dw1.valid", int'(valid1),   int'(m_valid[1]));
      check("dw1.wrap",  int'(wrap1),    int'(m_wrap[1]));
    end
  end

  initial begin
    int e4_sel, e4_wrap, e1_sel, e1_wrap;
    rst = 1'b1; en = 1'b0; load = 1'b0; load_sel = 2'd0; dir = 1'b0;
    @(posedge clk);
    cmp_on = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst.sel4",   int'({b4, a4}), 0);
    check("rst.valid4", int'(valid4),   0);
    check("rst.wrap4",  int'(wrap4),    0);
    check("rst.valid1", int'(valid1),   0);

    // Free run from reset; load 2 lands on the dwell-end edge 21.
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      if (i <= 20) begin
        e4_sel  = ((i - 1) / 4) % 4;
        e1_sel  = (i - 1) % 4;
        e1_wrap = (i > 1 && (i - 1) % 4 == 0) ? 1 : 0;
      end else begin
        e4_sel  = (i <= 24) ? 2 : 3;
        e1_sel  = (i - 19) % 4;
        e1_wrap = ((i - 19) % 4 == 0) ? 1 : 0;
      end
      e4_wrap = (i == 17) ? 1 : 0;
      check("run.sel4",   int'({b4, a4}), e4_sel);
      check("run.wrap4",  int'(wrap4),    e4_wrap);
      check("run.valid4", int'(valid4),   1);
      check("run.sel1",   int'({b1, a1}), e1_sel);
      check("run.wrap1",  int'(wrap1),    e1_wrap);
      if (i == 20) begin
        load = 1'b1; load_sel = 2'd2;
      end
      if (i == 21) load = 1'b0;
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 99) < 2);
      en       = ($urandom_range(0, 99) < 85);
      load     = ($urandom_range(0, 99) < 8);
      load_sel = 2'($urandom_range(0, 3));
`ifdef SCAN_DIR_EN
      if ($urandom_range(0, 15) == 0) dir = ~dir;
`endif
    end
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
